// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared types for the sequential radix-4 Booth multiplier.
//   state_t       : controller states (IDLE, RUN, DONE)
//   booth_digit_t : recoded Booth digit as {neg, two, zero} control bits
//   iter_count()  : radix-4 iterations needed for a width-bit operand pair
// Optional feature macro used by the multiplier: MULT_OVF_EN.
// -----------------------------------------------------------------------------
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // zero : digit is 0 (neg and two are don't-care)
   // two  : magnitude is 2 instead of 1
   // neg  : digit is negative
   typedef struct packed {
      logic neg;
      logic two;
      logic zero;
   } booth_digit_t;

   // Operands are extended by two bits, so (width+2)/2 digits cover them.
   function automatic int iter_count(input int width);
      return width / 2 + 1;
   endfunction

endpackage

// File: rtl/booth_recoder.sv
// -----------------------------------------------------------------------------
// booth_recoder
// Combinational radix-4 Booth recoder: three overlapping multiplier bits
// {b[i+1], b[i], b[i-1]} become a digit in {-2, -1, 0, +1, +2}.
// Ports:
//   bits  in  3  {b[i+1], b[i], b[i-1]}
//   neg   out 1  digit is negative
//   two   out 1  digit magnitude is 2
//   zero  out 1  digit is zero
// -----------------------------------------------------------------------------
module booth_recoder (
   input  logic [2:0] bits,
   output logic       neg,
   output logic       two,
   output logic       zero
);

   // 000 and 111 both recode to 0; 011 -> +2 and 100 -> -2.
   assign zero = (bits == 3'b000) || (bits == 3'b111);
   assign two  = (bits == 3'b011) || (bits == 3'b100);
   assign neg  = bits[2] & ~zero;

endmodule

// File: rtl/mult_booth_seq.sv
// -----------------------------------------------------------------------------
// mult_booth_seq
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or
// unsigned. One iteration per clock in RUN; result is registered and held
// until the next accepted operation completes.
// Optional feature: define MULT_OVF_EN to add the registered overflow output.
// Ports:
//   clk         in   1         rising-edge clock
//   reset       in   1         synchronous, active-high reset
//   start       in   1         request; operands sampled when accepted
//   is_signed   in   1         1 = two's-complement, 0 = unsigned
//   op_a        in   WIDTH     multiplicand
//   op_b        in   WIDTH     multiplier
//   busy        out  1         operation in progress (RUN)
//   result      out  2*WIDTH   held product
//   result_rdy  out  1         one-cycle pulse when result becomes valid
//   overflow    out  1         (MULT_OVF_EN) product does not fit in WIDTH bits
// -----------------------------------------------------------------------------
module mult_booth_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               busy,
   output logic [2*WIDTH-1:0] result,
`ifdef MULT_OVF_EN
   output logic               result_rdy,
   output logic               overflow
`else
   output logic               result_rdy
`endif
);

   localparam int ITER  = iter_count(WIDTH);
   localparam int CNT_W = $clog2(ITER);
   localparam int EW    = WIDTH + 2;      // extended operand width
   localparam int AW    = 2 * WIDTH + 4;  // accumulator width

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [EW-1:0]      a_q;
   logic [AW-1:0]      acc_q, acc_next;
   logic               b_prev_q;
   logic [2*WIDTH-1:0] result_q;
   logic               load, step, last;

   booth_digit_t       digit;
   logic [EW+1:0]      hi_ext, mag, sum;
   logic [EW-1:0]      a_ext, b_ext;

   // Sign- or zero-extend so one signed datapath serves both modes.
   assign a_ext = is_signed ? {{2{op_a[WIDTH-1]}}, op_a} : {2'b00, op_a};
   assign b_ext = is_signed ? {{2{op_b[WIDTH-1]}}, op_b} : {2'b00, op_b};

   assign last = (cnt_q == CNT_W'(ITER - 1));

   booth_recoder u_recoder (
      .bits ({acc_q[1], acc_q[0], b_prev_q}),
      .neg  (digit.neg),
      .two  (digit.two),
      .zero (digit.zero)
   );

   // Accumulator layout: {upper partial product (EW bits), multiplier (EW bits)}.
   // The add is done two bits wider so the +/-2A step cannot wrap before the
   // arithmetic shift by 2 brings it back into EW bits.
   assign hi_ext   = {{2{acc_q[AW-1]}}, acc_q[AW-1:EW]};
   assign mag      = digit.zero ? '0 :
                     digit.two  ? {a_q[EW-1], a_q, 1'b0} :
                                  {{2{a_q[EW-1]}}, a_q};
   assign sum      = digit.neg ? (hi_ext - mag) : (hi_ext + mag);
   assign acc_next = {sum, acc_q[EW-1:2]};

   // Controller: next state and strobes.
   always_comb begin
      // NOTE: every output gets a default first, so no path infers a latch.
      state_d    = state_q;
      load       = 1'b0;
      step       = 1'b0;
      busy       = 1'b0;
      result_rdy = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;  // start is ignored here
            if (last) state_d = DONE;
         end
         DONE: begin
            result_rdy = 1'b1;
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef MULT_OVF_EN
   logic                sign_q;
   logic                ovf_q;
   logic                ovf_next;
   logic [2*WIDTH-1:0]  prod;
   logic [WIDTH:0]      prod_top_s;

   assign prod       = acc_next[2*WIDTH-1:0];
   assign prod_top_s = prod[2*WIDTH-1:WIDTH-1];
   assign ovf_next   = sign_q ? !((&prod_top_s) || !(|prod_top_s))
                              : (|prod[2*WIDTH-1:WIDTH]);
   assign overflow   = ovf_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sign_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         if (load) sign_q <= is_signed;
         if (step && last) ovf_q <= ovf_next;
      end
   end
`endif

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         acc_q    <= '0;
         b_prev_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            a_q      <= a_ext;
            acc_q    <= {{EW{1'b0}}, b_ext};
            b_prev_q <= 1'b0;
            cnt_q    <= '0;
         end else if (step) begin
            acc_q    <= acc_next;
            b_prev_q <= acc_q[1];
            cnt_q    <= cnt_q + 1'b1;
            if (last) result_q <= acc_next[2*WIDTH-1:0];
         end
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_mult_booth_seq.sv
// -----------------------------------------------------------------------------
// tb_mult_booth_seq
// Directed bench for mult_booth_seq: a WIDTH=32 instance for the handshake,
// timing and corner products, and a WIDTH=8 instance for corner and random
// pairs against a reference product. Define MULT_OVF_EN to also check overflow.
// -----------------------------------------------------------------------------
module tb_mult_booth_seq;

   localparam int ITER32 = 17;  // 32/2 + 1 RUN cycles
   localparam int ITER8  = 5;   // 8/2 + 1 RUN cycles

   logic        clk = 1'b0;
   logic        reset;

   logic        start, is_signed;
   logic [31:0] op_a, op_b;
   logic        busy, result_rdy;
   logic [63:0] result;

   logic        start8, is_signed8;
   logic [7:0]  op_a8, op_b8;
   logic        busy8, result_rdy8;
   logic [15:0] result8;

`ifdef MULT_OVF_EN
   logic        overflow, overflow8;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mult_booth_seq #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .is_signed  (is_signed),
      .op_a       (op_a),
      .op_b       (op_b),
      .busy       (busy),
      .result     (result),
`ifdef MULT_OVF_EN
      .result_rdy (result_rdy),
      .overflow   (overflow)
`else
      .result_rdy (result_rdy)
`endif
   );

   mult_booth_seq #(.WIDTH(8)) dut8 (
      .clk        (clk),
      .reset      (reset),
      .start      (start8),
      .is_signed  (is_signed8),
      .op_a       (op_a8),
      .op_b       (op_b8),
      .busy       (busy8),
      .result     (result8),
`ifdef MULT_OVF_EN
      .result_rdy (result_rdy8),
      .overflow   (overflow8)
`else
      .result_rdy (result_rdy8)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands with start for exactly one edge (edge 0 of the operation).
   task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s);
      op_a      = a;
      op_b      = b;
      is_signed = s;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   // Count edges until result_rdy, starting from n0 edges already elapsed.
   task automatic wait32(input int n0, output int lat, output int busy_cycles);
      lat         = n0;
      busy_cycles = 0;
      while (!result_rdy && lat < 60) begin
         if (busy) busy_cycles++;
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat, bc, n, rdy_seen;
      logic [7:0]  va [3];
      logic [7:0]  vb [3];
      logic        vs [3];
      logic [15:0] vr [3];
      logic [7:0]  a8, b8;
      logic        s8;
      int          x, y;
      logic [15:0] ref8;

      reset = 1'b1;
      start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
      start8 = 1'b0; is_signed8 = 1'b0; op_a8 = '0; op_b8 = '0;
      tick();
      tick();
      check("reset_busy", busy, 0);
      check("reset_rdy", result_rdy, 0);
      check("reset_result", result, 0);
`ifdef MULT_OVF_EN
      check("reset_ovf", overflow, 0);
`endif
      reset = 1'b0;
      tick();

      // unsigned 3 x 2: timing, busy length and hold behaviour
      start32(32'd3, 32'd2, 1'b0);
      check("run_result_unchanged", result, 0);
      wait32(0, lat, bc);
      check("u3x2_latency", lat, ITER32);
      check("u3x2_busy_cycles", bc, ITER32);
      check("u3x2_result", result, 64'd6);
      tick();
      check("u3x2_rdy_one_cycle", result_rdy, 0);
      check("u3x2_idle_busy", busy, 0);
      check("u3x2_held", result, 64'd6);

      // signed -7 x 5 and the same operands unsigned
      start32(32'hFFFF_FFF9, 32'd5, 1'b1);
      wait32(0, lat, bc);
      check("s_m7x5", result, 64'hFFFF_FFFF_FFFF_FFDD);
      tick();
      start32(32'hFFFF_FFF9, 32'd5, 1'b0);
      wait32(0, lat, bc);
      check("u_m7x5", result, 64'h0000_0004_FFFF_FFDD);
      tick();

      // largest unsigned square
      start32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      wait32(0, lat, bc);
      check("u_max_sq", result, 64'hFFFF_FFFE_0000_0001);
`ifdef MULT_OVF_EN
      check("u_max_sq_ovf", overflow, 1);
`endif
      tick();

      // most negative signed square
      start32(32'h8000_0000, 32'h8000_0000, 1'b1);
      wait32(0, lat, bc);
      check("s_min_sq", result, 64'h4000_0000_0000_0000);
`ifdef MULT_OVF_EN
      check("s_min_sq_ovf", overflow, 1);
`endif
      tick();

      // small signed product fits
      start32(32'd4, 32'd5, 1'b1);
      wait32(0, lat, bc);
      check("s_4x5", result, 64'd20);
`ifdef MULT_OVF_EN
      check("s_4x5_ovf", overflow, 0);
`endif
      tick();

      // start pulsed during busy at edge 5 must be ignored
      start32(32'd3, 32'd2, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      op_a = 32'd100; op_b = 32'd100; is_signed = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_start_still_busy", busy, 1);
      check("busy_start_old_result", result, 64'd20);
      wait32(5, lat, bc);
      check("busy_start_latency", lat, ITER32);
      check("busy_start_result", result, 64'd6);

      // back-to-back: start accepted in the DONE cycle
      check("b2b_rdy_in_done", result_rdy, 1);
      start32(32'd7, 32'd9, 1'b0);
      check("b2b_busy", busy, 1);
      check("b2b_result_held", result, 64'd6);
      wait32(0, lat, bc);
      check("b2b_latency", lat, ITER32);
      check("b2b_result", result, 64'd63);
      tick();

      // reset mid-operation aborts with no result_rdy
      start32(32'd11, 32'd13, 1'b0);
      for (int i = 0; i < 7; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_result", result, 0);
      rdy_seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (result_rdy) rdy_seen++;
         tick();
      end
      check("abort_no_rdy", rdy_seen, 0);

      // WIDTH=8: hand-computed corners, then random pairs
      va[0] = 8'h80; vb[0] = 8'h80; vs[0] = 1'b1; vr[0] = 16'h4000;
      va[1] = 8'hFF; vb[1] = 8'hFF; vs[1] = 1'b0; vr[1] = 16'hFE01;
      va[2] = 8'hFF; vb[2] = 8'hFF; vs[2] = 1'b1; vr[2] = 16'h0001;
      for (int k = 0; k < 3; k++) begin
         op_a8 = va[k]; op_b8 = vb[k]; is_signed8 = vs[k]; start8 = 1'b1;
         tick();
         start8 = 1'b0;
         n = 0;
         while (!result_rdy8 && n < 40) begin tick(); n++; end
         check("w8_corner_latency", n, ITER8);
         check("w8_corner_result", result8, vr[k]);
      end

      for (int k = 0; k < 1000; k++) begin
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         s8 = 1'($urandom_range(0, 1));
         x  = s8 ? int'($signed(a8)) : int'(a8);
         y  = s8 ? int'($signed(b8)) : int'(b8);
         ref8 = 16'(x * y);
         op_a8 = a8; op_b8 = b8; is_signed8 = s8; start8 = 1'b1;
         tick();
         start8 = 1'b0;
         n = 0;
         while (!result_rdy8 && n < 40) begin tick(); n++; end
         check("w8_rand_latency", n, ITER8);
         check("w8_rand_result", result8, ref8);
`ifdef MULT_OVF_EN
         check("w8_rand_ovf", overflow8,
               s8 ? !((&ref8[15:7]) || !(|ref8[15:7])) : (|ref8[15:8]));
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
